motor_drive: RTL
================

// Module: motor_drive
// PURPOSE
//  Consumes the 2-bit steering command from the line tracker and drives the left and right motor H-bridges.
//  Outputs per motor: a direction pair and a PWM enable.
//  Holds the last command through brief line loss, pivots to search for the line, then halts if it stays lost.
//  Sits between the tracker stage and the top-level motor pins.
// PARAMETERS
//  PWM_PERIOD     1024         PWM counter period in clk cycles (counter runs 0..PWM_PERIOD-1)
//  DUTY_FAST      768          duty of the outer/straight motor (0..PWM_PERIOD)
//  DUTY_SLOW      256          duty of the inner motor in turns, and of both motors in search
//  LOST_CYCLES    5_000_000    consecutive cycles of cmd==00 before entering SEARCH
//  SEARCH_CYCLES  100_000_000  maximum cycles spent in SEARCH before IDLE
//  RAMP_STEP      16           duty change per PWM period (used only with MOTOR_RAMP_EN)
// PORTS
//  clk        in   1  system clock; single clock domain
//  reset      in   1  asynchronous, active-high reset
//  run        in   1  1 = drive allowed; 0 = forced IDLE
//  cmd        in   2  tracker state: 11 forward, 10 left, 01 right, 00 no line
//  dir_left   out  2  left H-bridge IN pair: 10 fwd, 01 rev, 00 coast
//  dir_right  out  2  right H-bridge IN pair, same encoding
//  pwm_left   out  1  left enable PWM
//  pwm_right  out  1  right enable PWM
//  mode       out  3  FSM state: 0 IDLE, 1 FWD, 2 TURN_L, 3 TURN_R, 4 SEARCH
// BEHAVIOUR
//  - Reset values: all outputs 0, mode=IDLE, all counters 0, duties 0, last_turn=LEFT.
//  - FSM update: registered, one cycle after cmd/run are sampled.
//  - run==0 from any state: IDLE next cycle, lost/search counters cleared; run has priority over cmd.
//  - cmd 11 -> FWD; 10 -> TURN_L with last_turn<=LEFT; 01 -> TURN_R with last_turn<=RIGHT.
//    These apply from every state when run==1.
//  - cmd==00 in IDLE: stay in IDLE.
//  - cmd==00 in FWD/TURN_*: hold state and increment lost_cnt.
//    When lost_cnt reaches LOST_CYCLES-1 on a 00 cycle -> SEARCH. Any nonzero cmd clears lost_cnt.
//  - SEARCH: pivot toward last_turn. LEFT = left rev/right fwd; RIGHT = left fwd/right rev. Both motors DUTY_SLOW.
//    After SEARCH_CYCLES cycles -> IDLE. A nonzero cmd exits SEARCH immediately per the mapping above.
//  - Targets: FWD both fwd FAST; TURN_L left fwd SLOW, right fwd FAST; TURN_R mirror; IDLE coast, duty 0.
//  - PWM: shared counter wraps at PWM_PERIOD-1; pwm_x = (cnt < duty_x).
//    duty 0 gives constant low; duty PWM_PERIOD gives constant high.
//  - Target duty and dir are latched into the active registers only on the wrap cycle, so no runt pulses.
//    Command-to-output latency is 1 cycle to mode, and at most PWM_PERIOD+1 cycles to the pins.
//  - Duty width is $clog2(PWM_PERIOD+1). Parameters above PWM_PERIOD are clamped to PWM_PERIOD.
//  - Reset mid-period: counter restarts at 0 and pins go low asynchronously.
// CONFIGURATION
//  MOTOR_RAMP_EN defined:
//  - At each wrap, active duty moves toward target by at most RAMP_STEP, saturating at the target.
//  - On a direction change the duty first ramps to 0, dir switches on the wrap where duty==0, then duty ramps up.
//  - IDLE from run==0 still ramps down; reset is always immediate.
//  MOTOR_RAMP_EN undefined: duty and dir take their target values on the next wrap.
// STRUCTURE
//  - motor_pkg: mode encoding, DIR_FWD/DIR_REV/DIR_COAST, CMD_* encodings, LEFT/RIGHT constants.
//  - Sub-module pwm_channel, instantiated twice.
//    Inputs: shared counter, wrap strobe, target dir and duty. Outputs: dir, pwm. Contains the ramp logic.
//  - Top holds the FSM, lost/search counters and the PWM counter.
// TESTING (bench params: PWM_PERIOD=16, DUTY_FAST=12, DUTY_SLOW=4, LOST_CYCLES=20, SEARCH_CYCLES=50, RAMP_STEP=4)
//  1. Reset, run=1, cmd=11 -> mode=1 next cycle.
//     After the next wrap: dir_left=dir_right=10, each pwm high 12 of every 16 cycles.
//  2. cmd=10 then cmd=00 for 19 cycles -> mode stays 2. Cycle 20 -> mode=4, dir_left=01, dir_right=10, duty 4/16.
//  3. In SEARCH, cmd stays 00 for 50 cycles -> mode=0, both dir=00, pwm low.
//  4. In SEARCH, cmd=01 -> mode=3 next cycle, lost_cnt=0. After wrap: left duty 12, right duty 4.
//  5. run=0 while in FWD with cmd=11 -> mode=0 next cycle. Assert reset mid-period -> all outputs 0 immediately.
//  6. MOTOR_RAMP_EN, FWD->SEARCH(LEFT): left duty steps 12,8,4,0 at wraps, dir_left 10->01 at duty 0, then 4.
//     Without the macro: jumps to duty 4 with dir 01 at the first wrap.

Source files
------------

// File: rtl/motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_pkg : mode, H-bridge direction and tracker command encodings         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package motor_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_FWD    = 3'd1,
    MODE_TURN_L = 3'd2,
    MODE_TURN_R = 3'd3,
    MODE_SEARCH = 3'd4
  } mode_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  localparam logic [1:0] CMD_FWD   = 2'b11;
  localparam logic [1:0] CMD_LEFT  = 2'b10;
  localparam logic [1:0] CMD_RIGHT = 2'b01;
  localparam logic [1:0] CMD_NONE  = 2'b00;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic int clamp_duty(input int value, input int period);
    return (value > period) ? period : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/motor_drive_pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pwm_channel : one H-bridge channel, dir/duty latched at PWM wrap           |
// | Optional duty ramping with MOTOR_RAMP_EN.  Rev 1.0                         |
// +----------------------------------------------------------------------------+
module pwm_channel #(
  parameter int PWM_PERIOD = 1024,
  parameter int RAMP_STEP  = 16,
  parameter int DW         = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] cnt,
  input  logic          wrap,
  input  logic [1:0]    tgt_dir,
  input  logic [DW-1:0] tgt_duty,
  output logic [1:0]    dir,
  output logic          pwm
);
  import motor_pkg::*;

`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  localparam int          STEP_I = (RAMP_STEP < 1) ? 1 : clamp_duty(RAMP_STEP, PWM_PERIOD);
  localparam logic [DW:0] STEP   = (DW+1)'(STEP_I);

  logic [1:0]    dir_q, dir_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW:0]   duty_x, tgt_x;
  logic [DW-1:0] down, toward;

  always_comb begin
    duty_x = {1'b0, duty_q};
    tgt_x  = {1'b0, tgt_duty};
    down   = (duty_x > STEP) ? DW'(duty_x - STEP) : '0;
    if (duty_x > tgt_x) begin
      toward = (duty_x - tgt_x > STEP) ? DW'(duty_x - STEP) : tgt_duty;
    end else begin
      toward = (tgt_x - duty_x > STEP) ? DW'(duty_x + STEP) : tgt_duty;
    end
    dir_d  = dir_q;
    duty_d = duty_q;
    if (wrap) begin
      if (!RAMP_EN) begin
        dir_d  = tgt_dir;
        duty_d = tgt_duty;
      end else if (dir_q != tgt_dir) begin
        // never reverse a bridge under load: wind down first, flip at zero
        duty_d = down;
        if (down == '0) dir_d = tgt_dir;
      end else begin
        duty_d = toward;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q  <= DIR_COAST;
      duty_q <= '0;
    end else begin
      dir_q  <= dir_d;
      duty_q <= duty_d;
    end
  end

  assign dir = dir_q;
  assign pwm = (cnt < duty_q);

endmodule
`default_nettype wire

// File: rtl/motor_drive.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_drive : line-tracker steering FSM driving two PWM H-bridge channels  |
// | Option macro: MOTOR_RAMP_EN (duty ramping).  Rev 1.0                       |
// +----------------------------------------------------------------------------+
module motor_drive #(
  parameter int PWM_PERIOD    = 1024,
  parameter int DUTY_FAST     = 768,
  parameter int DUTY_SLOW     = 256,
  parameter int LOST_CYCLES   = 5_000_000,
  parameter int SEARCH_CYCLES = 100_000_000,
  parameter int RAMP_STEP     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] cmd,
  output logic [1:0] dir_left,
  output logic [1:0] dir_right,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic [2:0] mode
);
  import motor_pkg::*;

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam int SW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;

  localparam logic [DW-1:0] FAST        = DW'(clamp_duty(DUTY_FAST, PWM_PERIOD));
  localparam logic [DW-1:0] SLOW        = DW'(clamp_duty(DUTY_SLOW, PWM_PERIOD));
  localparam logic [DW-1:0] CNT_LAST    = DW'(PWM_PERIOD - 1);
  localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_CYCLES - 1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_CYCLES - 1);

  mode_e         mode_q, mode_d;
  logic          last_turn_q, last_turn_d;
  logic [LW-1:0] lost_cnt_q, lost_cnt_d;
  logic [SW-1:0] search_cnt_q, search_cnt_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          wrap;

  logic [1:0]    tgt_dir_left, tgt_dir_right;
  logic [DW-1:0] tgt_duty_left, tgt_duty_right;

  assign wrap  = (cnt_q == CNT_LAST);
  assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

  always_comb begin
    mode_d       = mode_q;
    last_turn_d  = last_turn_q;
    lost_cnt_d   = lost_cnt_q;
    search_cnt_d = '0;
    if (!run) begin
      mode_d     = MODE_IDLE;
      lost_cnt_d = '0;
    end else begin
      case (cmd)
        CMD_FWD: begin
          mode_d     = MODE_FWD;
          lost_cnt_d = '0;
        end
        CMD_LEFT: begin
          mode_d      = MODE_TURN_L;
          last_turn_d = LEFT;
          lost_cnt_d  = '0;
        end
        CMD_RIGHT: begin
          mode_d      = MODE_TURN_R;
          last_turn_d = RIGHT;
          lost_cnt_d  = '0;
        end
        default: begin
          case (mode_q)
            MODE_IDLE: lost_cnt_d = '0;
            MODE_SEARCH: begin
              if (search_cnt_q == SEARCH_LAST) mode_d = MODE_IDLE;
              else search_cnt_d = search_cnt_q + 1'b1;
            end
            default: begin
              // line lost while driving: coast on the last command until patience runs out
              if (lost_cnt_q == LOST_LAST) begin
                mode_d     = MODE_SEARCH;
                lost_cnt_d = '0;
              end else begin
                lost_cnt_d = lost_cnt_q + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_IDLE;
      last_turn_q  <= LEFT;
      lost_cnt_q   <= '0;
      search_cnt_q <= '0;
      cnt_q        <= '0;
    end else begin
      mode_q       <= mode_d;
      last_turn_q  <= last_turn_d;
      lost_cnt_q   <= lost_cnt_d;
      search_cnt_q <= search_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    tgt_dir_left   = DIR_COAST;
    tgt_dir_right  = DIR_COAST;
    tgt_duty_left  = '0;
    tgt_duty_right = '0;
    case (mode_q)
      MODE_FWD: begin
        tgt_dir_left   = DIR_FWD;
        tgt_dir_right  = DIR_FWD;
        tgt_duty_left  = FAST;
        tgt_duty_right = FAST;
      end
      MODE_TURN_L: begin
        tgt_dir_left   = DIR_FWD;
        tgt_dir_right  = DIR_FWD;
        tgt_duty_left  = SLOW;
        tgt_duty_right = FAST;
      end
      MODE_TURN_R: begin
        tgt_dir_left   = DIR_FWD;
        tgt_dir_right  = DIR_FWD;
        tgt_duty_left  = FAST;
        tgt_duty_right = SLOW;
      end
      MODE_SEARCH: begin
        tgt_dir_left   = (last_turn_q == LEFT) ? DIR_REV : DIR_FWD;
        tgt_dir_right  = (last_turn_q == LEFT) ? DIR_FWD : DIR_REV;
        tgt_duty_left  = SLOW;
        tgt_duty_right = SLOW;
      end
      default: ;
    endcase
  end

  pwm_channel #(.PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DW(DW)) u_left (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt_q),
    .wrap     (wrap),
    .tgt_dir  (tgt_dir_left),
    .tgt_duty (tgt_duty_left),
    .dir      (dir_left),
    .pwm      (pwm_left)
  );

  pwm_channel #(.PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DW(DW)) u_right (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt_q),
    .wrap     (wrap),
    .tgt_dir  (tgt_dir_right),
    .tgt_duty (tgt_duty_right),
    .dir      (dir_right),
    .pwm      (pwm_right)
  );

  assign mode = mode_q;

endmodule
`default_nettype wire
